// File: rtl/ex_wb_if.sv
// Decode-to-execute handshake plus the side load and debug ports of the data memory.
interface ex_wb_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_LEN  = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           alu_sig;
  logic [ADDR_LEN-1:0]  oper1;
  logic [ADDR_LEN-1:0]  oper2;
  logic [ADDR_LEN-1:0]  dest;
  logic                 ld_en;
  logic [ADDR_LEN-1:0]  ld_addr;
  logic [WORD_SIZE-1:0] ld_data;
  logic [ADDR_LEN-1:0]  dbg_addr;
  logic [WORD_SIZE-1:0] dbg_data;
  logic [WORD_SIZE-1:0] result;
  logic                 carry;
  logic                 done;

  modport master (
    output in_valid, alu_sig, oper1, oper2, dest, ld_en, ld_addr, ld_data, dbg_addr,
    input  in_ready, dbg_data, result, carry, done
  );
  modport slave (
    input  in_valid, alu_sig, oper1, oper2, dest, ld_en, ld_addr, ld_data, dbg_addr,
    output in_ready, dbg_data, result, carry, done
  );
endinterface

// File: rtl/ex_wb_stage.sv
// Execute/write-back stage: fixed 3-cycle read/execute/write-back over an internal
// register-style data memory, with a side load port and a combinational debug read.
module ex_wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 32,
  parameter int ADDR_LEN  = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_wb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [ADDR_LEN-1:0]  a_addr_q, b_addr_q, dest_q;
  logic [WORD_SIZE-1:0] a_q, b_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 carry_q;
  logic                 done_q;
  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [WORD_SIZE:0]   alu_ext;
  logic                 accept, load;

  // Loads are only taken in IDLE and beat a simultaneous instruction.
  assign load         = (state_q == IDLE) && bus.ld_en;
  assign bus.in_ready = (state_q == IDLE) && !bus.ld_en && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD;
      RD:      state_d = EX;
      EX:      state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Extended width gives ADD carry-out and SUB borrow in the top bit.
  always_comb begin
    case (op_q)
      2'b00:   alu_ext = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   alu_ext = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   alu_ext = {1'b0, a_q & b_q};
      default: alu_ext = {1'b0, a_q | b_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == WB);
      if (accept) begin
        op_q     <= bus.alu_sig;
        a_addr_q <= bus.oper1;
        b_addr_q <= bus.oper2;
        dest_q   <= bus.dest;
      end
      if (state_q == RD) begin
        a_q <= mem_q[a_addr_q];
        b_q <= mem_q[b_addr_q];
      end
      if (state_q == EX) begin
        result_q <= alu_ext[WORD_SIZE-1:0];
        carry_q  <= alu_ext[WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
    end else if (state_q == WB) begin
      mem_q[dest_q] <= result_q;
    end else if (load) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign bus.dbg_data = mem_q[bus.dbg_addr];
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.done     = done_q;
endmodule
